// File: rtl/vec_alu_seq_pkg.sv
// Shared constants, opcodes, FSM states and address packing for the vector ALU sequencer.
package vec_pkg;

    localparam int VLEN    = 8;
    localparam int NREG    = 8;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = $clog2(NREG);
    localparam int ELEM_AW = $clog2(VLEN);
    localparam int ADDR_W  = REG_AW + ELEM_AW;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Register-file address: register index in the high bits, element index in the low bits.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [REG_AW-1:0] r,
                                                    input logic [ELEM_AW-1:0] e);
        return {r, e};
    endfunction

endpackage

// File: rtl/vec_alu_seq_if.sv
// Command handshake and register-file bus of the vector ALU sequencer.
// VSEQ_MASK_EN adds the per-element command mask.
interface vec_alu_seq_if;
    import vec_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_op;
    logic [REG_AW-1:0]   cmd_vd;
    logic [REG_AW-1:0]   cmd_vs1;
    logic [REG_AW-1:0]   cmd_vs2;
    logic [ELEM_AW:0]    cmd_vl;
`ifdef VSEQ_MASK_EN
    logic [VLEN-1:0]     cmd_mask;
`endif
    logic [ADDR_W-1:0]   rf_raddr1;
    logic [ADDR_W-1:0]   rf_raddr2;
    logic [DATA_W-1:0]   rf_rdata1;
    logic [DATA_W-1:0]   rf_rdata2;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic                done;
    logic                err;
    logic [VLEN-1:0]     zmask;

    modport master (
        output cmd_valid, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_vl,
`ifdef VSEQ_MASK_EN
        output cmd_mask,
`endif
        output rf_rdata1, rf_rdata2,
        input  cmd_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        input  done, err, zmask
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_vl,
`ifdef VSEQ_MASK_EN
        input  cmd_mask,
`endif
        input  rf_rdata1, rf_rdata2,
        output cmd_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        output done, err, zmask
    );

endinterface

// File: rtl/vec_alu_seq_alu.sv
// Shared 32-bit combinational scalar ALU; unknown opcodes produce zero.
module vec_alu_seq_alu
    import vec_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_SLL:  result = a << b[4:0];
            OP_SRL:  result = a >> b[4:0];
            OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/vec_alu_seq.sv
// Vector ALU sequencer: streams one element per cycle through the shared scalar ALU.
// Optional per-element write mask enabled by defining VSEQ_MASK_EN.
module vec_alu_seq
    import vec_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    vec_alu_seq_if.slave  bus
);

    state_t              state;
    logic [3:0]          op_q;
    logic [REG_AW-1:0]   vd_q;
    logic [REG_AW-1:0]   vs1_q;
    logic [REG_AW-1:0]   vs2_q;
    logic [ELEM_AW:0]    vl_q;
    logic [ELEM_AW-1:0]  elem;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;
    logic                elem_on;
    logic                elem_last;
`ifdef VSEQ_MASK_EN
    logic [VLEN-1:0]     mask_q;
    assign elem_on = mask_q[elem];
`else
    assign elem_on = 1'b1;
`endif

    assign bus.rf_raddr1 = pack_addr(vs1_q, elem);
    assign bus.rf_raddr2 = pack_addr(vs2_q, elem);
    assign elem_last     = (({1'b0, elem} + (ELEM_AW+1)'(1)) == vl_q);

    vec_alu_seq_alu u_alu (
        .op     (op_q),
        .a      (bus.rf_rdata1),
        .b      (bus.rf_rdata2),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // cmd_ready is registered so it stays low through reset and for the cycle carrying done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b0;
            bus.rf_we     <= 1'b0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.zmask     <= '0;
            op_q          <= '0;
            vd_q          <= '0;
            vs1_q         <= '0;
            vs2_q         <= '0;
            vl_q          <= '0;
            elem          <= '0;
`ifdef VSEQ_MASK_EN
            mask_q        <= '0;
`endif
        end else begin
            bus.rf_we <= 1'b0;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_ready && bus.cmd_valid) begin
                        bus.cmd_ready <= 1'b0;
                        op_q          <= bus.cmd_op;
                        vd_q          <= bus.cmd_vd;
                        vs1_q         <= bus.cmd_vs1;
                        vs2_q         <= bus.cmd_vs2;
                        vl_q          <= bus.cmd_vl;
                        elem          <= '0;
                        bus.zmask     <= '0;
`ifdef VSEQ_MASK_EN
                        mask_q        <= bus.cmd_mask;
`endif
                        if (bus.cmd_vl == '0 || bus.cmd_op > OP_SRA)
                            state <= FIN;
                        else
                            state <= RUN;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                RUN: begin
                    bus.rf_we       <= elem_on;
                    bus.rf_waddr    <= pack_addr(vd_q, elem);
                    bus.rf_wdata    <= alu_result;
                    bus.zmask[elem] <= alu_zero & elem_on;
                    if (elem_last) begin
                        state    <= IDLE;
                        bus.done <= 1'b1;
                    end else begin
                        elem <= elem + ELEM_AW'(1);
                    end
                end
                FIN: begin
                    bus.done <= 1'b1;
                    bus.err  <= (op_q > OP_SRA);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Scoreboard bench for vec_alu_seq: expected writes are queued at issue and checked as rf_we appears.
module tb_vec_alu_seq;
    import vec_pkg::*;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;
    int   done_count = 0;
    int   last_done_cyc = -1;
    logic last_err;
    logic [VLEN-1:0] last_zmask;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [DATA_W-1:0] rf [0:NREG*VLEN-1];
`ifdef VSEQ_MASK_EN
    logic [VLEN-1:0] cur_mask = '1;
`endif

    vec_alu_seq_if bus();

    vec_alu_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.rf_rdata1 = rf[bus.rf_raddr1];
    assign bus.rf_rdata2 = rf[bus.rf_raddr2];

    always @(posedge clk) begin
        if (bus.rf_we === 1'b1) rf[bus.rf_waddr] <= bus.rf_wdata;
    end

    // Scoreboard: every write seen must match the head of the expected queue, including its cycle.
    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write addr=%0h data=%h cyc=%0d", bus.rf_waddr, bus.rf_wdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rf_waddr !== mon_e.addr || bus.rf_wdata !== mon_e.data || cyc != mon_e.cyc)
                begin
                    errors++;
                    $display("[TB] FAIL write got addr=%0h data=%h cyc=%0d exp addr=%0h data=%h cyc=%0d",
                             bus.rf_waddr, bus.rf_wdata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
        if (bus.done === 1'b1) begin
            done_count++;
            last_done_cyc = cyc;
            last_err      = bus.err;
            last_zmask    = bus.zmask;
        end
    end

    function automatic logic [DATA_W-1:0] model_alu(input logic [3:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    task automatic preload(input logic [REG_AW-1:0] r, input int e, input logic [DATA_W-1:0] v);
        rf[pack_addr(r, ELEM_AW'(e))] <= v;
    endtask

    task automatic fill_random(input logic [REG_AW-1:0] r);
        for (int e = 0; e < VLEN; e++) preload(r, e, $urandom());
    endtask

    task automatic push_one(input int c, input logic [REG_AW-1:0] r, input int e, input logic [DATA_W-1:0] d);
        wr_t w;
        w.cyc  = c;
        w.addr = pack_addr(r, ELEM_AW'(e));
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic push_expected(input logic [3:0] op, input logic [REG_AW-1:0] vd,
                                 input logic [REG_AW-1:0] vs1, input logic [REG_AW-1:0] vs2,
                                 input int nwr, input int t0, output logic [VLEN-1:0] zexp);
        logic [VLEN-1:0]   m;
        logic [DATA_W-1:0] r;
`ifdef VSEQ_MASK_EN
        m = cur_mask;
`else
        m = '1;
`endif
        zexp = '0;
        if (op <= 4'd7) begin
            for (int k = 0; k < nwr; k++) begin
                r = model_alu(op, rf[pack_addr(vs1, ELEM_AW'(k))], rf[pack_addr(vs2, ELEM_AW'(k))]);
                if (m[k]) begin
                    push_one(t0 + k + 1, vd, k, r);
                    zexp[k] = (r == '0);
                end
            end
        end
    endtask

    // Offers a command with cmd_valid held until accepted; returns the cycle index just after acceptance.
    task automatic issue(input logic [3:0] op, input logic [REG_AW-1:0] vd,
                         input logic [REG_AW-1:0] vs1, input logic [REG_AW-1:0] vs2,
                         input logic [ELEM_AW:0] vl, output int t0);
        int waitn;
        bus.cmd_op    = op;
        bus.cmd_vd    = vd;
        bus.cmd_vs1   = vs1;
        bus.cmd_vs2   = vs2;
        bus.cmd_vl    = vl;
`ifdef VSEQ_MASK_EN
        bus.cmd_mask  = cur_mask;
`endif
        bus.cmd_valid = 1'b1;
        waitn = 0;
        while (bus.cmd_ready !== 1'b1 && waitn < 100) begin
            @(negedge clk); #1;
            waitn++;
        end
        if (waitn >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout cmd_ready=%b required 1", bus.cmd_ready);
        end
        @(posedge clk);
        @(negedge clk); #1;
        bus.cmd_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int dcyc, output logic derr, output logic [VLEN-1:0] dz,
                             output logic rdy);
        int start;
        start = done_count;
        dcyc  = -1;
        derr  = 1'bx;
        dz    = 'x;
        rdy   = 1'bx;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); #1;
            if (done_count != start) begin
                dcyc = last_done_cyc;
                derr = last_err;
                dz   = last_zmask;
                rdy  = bus.cmd_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %b required 0", bus.cmd_ready); end
        checks++;
        if (bus.rf_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_we got %b required 0", bus.rf_we); end
        checks++;
        if (bus.rf_waddr !== '0 || bus.rf_wdata !== '0) begin
            errors++; $display("[TB] FAIL rst_wbus got %0h/%h required 0/0", bus.rf_waddr, bus.rf_wdata);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_done_err got %b/%b required 0/0", bus.done, bus.err);
        end
        checks++;
        if (bus.zmask !== '0) begin errors++; $display("[TB] FAIL rst_zmask got %b required 0", bus.zmask); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready got %b required 1", bus.cmd_ready); end
    endtask

    task automatic test_add();
        int t0, dcyc;
        logic derr, rdy;
        logic [VLEN-1:0] dz;
        for (int e = 0; e < 4; e++) begin
            preload(3'd1, e, 32'(e + 1));
            preload(3'd2, e, 32'((e + 1) * 10));
        end
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 4'd4, t0);
        push_one(t0 + 1, 3'd3, 0, 32'd11);
        push_one(t0 + 2, 3'd3, 1, 32'd22);
        push_one(t0 + 3, 3'd3, 2, 32'd33);
        push_one(t0 + 4, 3'd3, 3, 32'd44);
        wait_done(dcyc, derr, dz, rdy);
        checks++;
        if (dcyc != t0 + 4) begin errors++; $display("[TB] FAIL add_done_cycle got %0d required %0d", dcyc, t0 + 4); end
        checks++;
        if (derr !== 1'b0 || dz !== 8'h00) begin errors++; $display("[TB] FAIL add_err_zmask got %b/%b required 0/0", derr, dz); end
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL add_ready_at_done got %b required 0", rdy); end
        @(negedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_ready_after got %b required 1", bus.cmd_ready); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL add_missing_writes got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_sub_zero();
        int t0, dcyc;
        logic derr, rdy;
        logic [VLEN-1:0] dz;
        logic [DATA_W-1:0] a [4] = '{32'd5, 32'd7, 32'd9, 32'd0};
        logic [DATA_W-1:0] b [4] = '{32'd5, 32'd1, 32'd9, 32'd0};
        for (int e = 0; e < 4; e++) begin
            preload(3'd4, e, a[e]);
            preload(3'd5, e, b[e]);
        end
        issue(OP_SUB, 3'd6, 3'd4, 3'd5, 4'd4, t0);
        push_one(t0 + 1, 3'd6, 0, 32'd0);
        push_one(t0 + 2, 3'd6, 1, 32'd6);
        push_one(t0 + 3, 3'd6, 2, 32'd0);
        push_one(t0 + 4, 3'd6, 3, 32'd0);
        wait_done(dcyc, derr, dz, rdy);
        checks++;
        if (dz !== 8'b0000_1101) begin errors++; $display("[TB] FAIL sub_zmask got %b required 00001101", dz); end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.zmask !== 8'b0000_1101) begin errors++; $display("[TB] FAIL sub_zmask_hold got %b required 00001101", bus.zmask); end
    endtask

    task automatic test_boundaries();
        int t0, dcyc, wc;
        logic derr, rdy;
        logic [VLEN-1:0] dz;
        wc = wr_count;
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 4'd0, t0);
        wait_done(dcyc, derr, dz, rdy);
        checks++;
        if (dcyc != t0 + 1) begin errors++; $display("[TB] FAIL vl0_done_cycle got %0d required %0d", dcyc, t0 + 1); end
        checks++;
        if (derr !== 1'b0 || dz !== 8'h00) begin errors++; $display("[TB] FAIL vl0_err_zmask got %b/%b required 0/0", derr, dz); end
        issue(4'd9, 3'd3, 3'd1, 3'd2, 4'd8, t0);
        wait_done(dcyc, derr, dz, rdy);
        checks++;
        if (dcyc != t0 + 1) begin errors++; $display("[TB] FAIL badop_done_cycle got %0d required %0d", dcyc, t0 + 1); end
        checks++;
        if (derr !== 1'b1) begin errors++; $display("[TB] FAIL badop_err got %b required 1", derr); end
        checks++;
        if (wr_count != wc) begin errors++; $display("[TB] FAIL noop_writes got %0d required 0", wr_count - wc); end
    endtask

    task automatic test_all_ops();
        int t0, dcyc, wc;
        logic derr, rdy;
        logic [VLEN-1:0] dz, zexp;
        logic [DATA_W-1:0] v;
        for (int op = 0; op < 8; op++) begin
            fill_random(3'd0);
            fill_random(3'd7);
            v = $urandom();
            preload(3'd0, 3, v);
            preload(3'd7, 3, v);
            @(negedge clk); #1;
            wc = wr_count;
            issue(4'(op), 3'd5, 3'd0, 3'd7, 4'd8, t0);
            push_expected(4'(op), 3'd5, 3'd0, 3'd7, VLEN, t0, zexp);
            wait_done(dcyc, derr, dz, rdy);
            checks++;
            if (dcyc != t0 + 8 || derr !== 1'b0) begin
                errors++; $display("[TB] FAIL op%0d_done got cyc %0d err %b required %0d/0", op, dcyc, derr, t0 + 8);
            end
            checks++;
            if (dz !== zexp || wr_count - wc != VLEN) begin
                errors++; $display("[TB] FAIL op%0d_zmask_count got %b/%0d required %b/%0d", op, dz, wr_count - wc, zexp, VLEN);
            end
        end
    endtask

    task automatic test_in_place_sra();
        int t0, dcyc;
        logic derr, rdy;
        logic [VLEN-1:0] dz;
        preload(3'd2, 0, 32'h8000_0000);
        preload(3'd3, 0, 32'd4);
        preload(3'd2, 1, 32'h7000_0000);
        preload(3'd3, 1, 32'd36);
        @(negedge clk); #1;
        issue(OP_SRA, 3'd2, 3'd2, 3'd3, 4'd2, t0);
        push_one(t0 + 1, 3'd2, 0, 32'hF800_0000);
        push_one(t0 + 2, 3'd2, 1, 32'h0700_0000);
        wait_done(dcyc, derr, dz, rdy);
        checks++;
        if (dcyc != t0 + 2 || dz !== 8'h00) begin
            errors++; $display("[TB] FAIL sra_done got cyc %0d zmask %b required %0d/0", dcyc, dz, t0 + 2);
        end
    endtask

    task automatic test_back_to_back();
        int ta, tb, dcyc, dc;
        logic derr, rdy;
        logic [VLEN-1:0] dz, za, zb;
        fill_random(3'd0);
        fill_random(3'd1);
        @(negedge clk); #1;
        dc = done_count;
        issue(OP_ADD, 3'd6, 3'd0, 3'd1, 4'd3, ta);
        push_expected(OP_ADD, 3'd6, 3'd0, 3'd1, 3, ta, za);
        issue(OP_XOR, 3'd6, 3'd6, 3'd6, 4'd3, tb);
        checks++;
        if (done_count != dc + 1 || tb != last_done_cyc + 2) begin
            errors++; $display("[TB] FAIL b2b_accept got cyc %0d required %0d", tb, last_done_cyc + 2);
        end
        push_expected(OP_XOR, 3'd6, 3'd6, 3'd6, 3, tb, zb);
        wait_done(dcyc, derr, dz, rdy);
        checks++;
        if (dcyc != tb + 3 || dz !== 8'b0000_0111) begin
            errors++; $display("[TB] FAIL b2b_second got cyc %0d zmask %b required %0d/00000111", dcyc, dz, tb + 3);
        end
    endtask

    task automatic test_reset_mid_run();
        int t0, wc, dc;
        logic [VLEN-1:0] zexp;
        fill_random(3'd0);
        fill_random(3'd7);
        @(negedge clk); #1;
        wc = wr_count;
        dc = done_count;
        issue(OP_ADD, 3'd4, 3'd0, 3'd7, 4'd8, t0);
        push_expected(OP_ADD, 3'd4, 3'd0, 3'd7, 2, t0, zexp);
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_outputs got we %b ready %b required 0/0", bus.rf_we, bus.cmd_ready);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b required 1", bus.cmd_ready); end
        checks++;
        if (wr_count - wc != 2 || done_count != dc || exp_q.size() != 0) begin
            errors++; $display("[TB] FAIL midrst_writes got %0d writes %0d dones required 2/0", wr_count - wc, done_count - dc);
        end
    endtask

`ifdef VSEQ_MASK_EN
    task automatic test_mask();
        int t0, dcyc, wc;
        logic derr, rdy;
        logic [VLEN-1:0] dz, zexp;
        fill_random(3'd0);
        fill_random(3'd7);
        preload(3'd0, 2, 32'd0);
        preload(3'd7, 2, 32'd0);
        preload(3'd0, 1, 32'd0);
        preload(3'd7, 1, 32'd0);
        @(negedge clk); #1;
        cur_mask = 8'b1010_0101;
        wc = wr_count;
        issue(OP_OR, 3'd5, 3'd0, 3'd7, 4'd8, t0);
        push_expected(OP_OR, 3'd5, 3'd0, 3'd7, VLEN, t0, zexp);
        wait_done(dcyc, derr, dz, rdy);
        checks++;
        if (dcyc != t0 + 8 || wr_count - wc != 4) begin
            errors++; $display("[TB] FAIL mask_done got cyc %0d writes %0d required %0d/4", dcyc, wr_count - wc, t0 + 8);
        end
        checks++;
        if (dz !== zexp || dz[1] !== 1'b0) begin errors++; $display("[TB] FAIL mask_zmask got %b required %b", dz, zexp); end
        cur_mask = '1;
    endtask
`endif

    initial begin
        for (int i = 0; i < NREG * VLEN; i++) rf[i] = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_vd    = '0;
        bus.cmd_vs1   = '0;
        bus.cmd_vs2   = '0;
        bus.cmd_vl    = '0;
`ifdef VSEQ_MASK_EN
        bus.cmd_mask  = '1;
`endif
        test_reset();
        test_add();
        test_sub_zero();
        test_boundaries();
        test_all_ops();
        test_in_place_sra();
        test_back_to_back();
        test_reset_mid_run();
`ifdef VSEQ_MASK_EN
        test_mask();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL leftover_writes got %0d required 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

endmodule
